xadc_drp_arbiter: RTL and testbench

Shares the single XADC DRP port between two requesters: port 0, the streaming sample reader that pulls conversion results after each end-of-sequence, and port 1, a configuration/status master (register writes, alarm and status reads). It serialises transactions, keeps exactly one DRP access outstanding, and round-robins between requesters. A per-transaction timeout guards against a missing drdy. It sits between the requesters and the XADC IP's DRP pins, in the sys_clk domain.

---
 rtl/xadc_drp_arbiter.sv | 131 +++++++++++++
 tb/tb_xadc_drp_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_drp_arbiter.sv
// Two-port round-robin arbiter in front of the single XADC DRP port, one access outstanding.
// Latency: handshake T, den T+1, earliest drdy T+2, response strobe T+3, next accept T+4.
// Backpressure: reqN_ready only in IDLE for the granted port; responses are strobes with no backpressure.
//
// Ports:
//   clk, rst                      DRP clock, asynchronous active-high reset
//   req{0,1}_valid/ready/addr/we/wdata   requester command channels
//   rsp{0,1}_valid/rdata/timeout  one-cycle response strobes, rdata held until the next response
//   drp_den/dwe/daddr/di/drdy/do  XADC DRP pins
//   busy                          a transaction is in flight (state is not IDLE)
module xadc_drp_arbiter #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic                  req0_we,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp0_timeout,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic                  req1_we,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic                  rsp1_timeout,
    output logic                  drp_den,
    output logic                  drp_dwe,
    output logic [ADDR_WIDTH-1:0] drp_daddr,
    output logic [DATA_WIDTH-1:0] drp_di,
    input  logic                  drp_drdy,
    input  logic [DATA_WIDTH-1:0] drp_do,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Counter wide enough for the largest legal timeout (1023).
    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic       last_grant;
    logic       owner;
    logic       cap_we;
    logic [9:0] cnt;
    logic       grant0;
    logic       grant1;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            cap_we       <= 1'b0;
            cnt          <= '0;
            drp_den      <= 1'b0;
            drp_dwe      <= 1'b0;
            drp_daddr    <= '0;
            drp_di       <= '0;
            rsp0_valid   <= 1'b0;
            rsp0_rdata   <= '0;
            rsp0_timeout <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp1_rdata   <= '0;
            rsp1_timeout <= 1'b0;
        end else begin
            // Strobes are high only for the single cycle of ISSUE / RESP.
            drp_den    <= 1'b0;
            drp_dwe    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner      <= grant1;
                        last_grant <= grant1;
                        // The DRP address/data registers double as the capture registers.
                        drp_daddr  <= grant1 ? req1_addr  : req0_addr;
                        drp_di     <= grant1 ? req1_wdata : req0_wdata;
                        cap_we     <= grant1 ? req1_we    : req0_we;
                        drp_dwe    <= grant1 ? req1_we    : req0_we;
                        drp_den    <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 10'd1;
                    // drdy wins over the timeout when both land in the same cycle.
                    if (drp_drdy || (cnt == CNT_LAST)) begin
                        state <= RESP;
                        if (owner) begin
                            rsp1_valid   <= 1'b1;
                            rsp1_timeout <= !drp_drdy;
                            rsp1_rdata   <= (drp_drdy && !cap_we) ? drp_do : '0;
                        end else begin
                            rsp0_valid   <= 1'b1;
                            rsp0_timeout <= !drp_drdy;
                            rsp0_rdata   <= (drp_drdy && !cap_we) ? drp_do : '0;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Self-checking bench for xadc_drp_arbiter: scoreboard of expected DRP issues and responses.
// A behavioural DRP slave answers each den after a programmable number of cycles (or never).
// Responses are checked against the queue head as they appear; leftovers are flagged at the end.
module tb_xadc_drp_arbiter;

    localparam int AW = 7;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          rsp0_valid, rsp0_timeout;
    logic [DW-1:0] rsp0_rdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp1_valid, rsp1_timeout;
    logic [DW-1:0] rsp1_rdata;
    logic          drp_den, drp_dwe, drp_drdy;
    logic [AW-1:0] drp_daddr;
    logic [DW-1:0] drp_di, drp_do;
    logic          busy;

    xadc_drp_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_we(req0_we), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_timeout(rsp0_timeout),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_we(req1_we), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_timeout(rsp1_timeout),
        .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
        .drp_drdy(drp_drdy), .drp_do(drp_do), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
        bit            to;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        bit            we;
        logic [DW-1:0] wdata;
    } iss_t;

    rsp_t          sb[$];
    iss_t          iq[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            drp_lat = -1;      // cycles from den to drdy; negative means never answer
    logic [DW-1:0] drp_val = '0;
    int            pend = 0;
    int            den_cyc = -1;
    int            den_prev = -1;
    int            hs_cyc = 0;
    int            rsp_cyc = 0;
    logic [DW-1:0] hold0 = '0;
    logic [DW-1:0] hold1 = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic do_req(input bit port, input logic [AW-1:0] addr, input bit we,
                          input logic [DW-1:0] wdata, input int lat, input logic [DW-1:0] dval,
                          input bit exp_to, input bit wait_rsp);
        int   t;
        iss_t ei;
        rsp_t er;
        drp_lat = lat;
        drp_val = dval;
        @(posedge clk);
        #1;
        if (port) begin
            req1_valid = 1'b1; req1_addr = addr; req1_we = we; req1_wdata = wdata;
        end else begin
            req0_valid = 1'b1; req0_addr = addr; req0_we = we; req0_wdata = wdata;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(port ? req1_ready : req0_ready) && t < 50);
        check("grant", port ? req1_ready : req0_ready, 1);
        hs_cyc   = cyc;
        ei.addr  = addr; ei.we = we; ei.wdata = wdata;
        iq.push_back(ei);
        er.port  = port;
        er.data  = (exp_to || we) ? '0 : dval;
        er.to    = exp_to;
        sb.push_back(er);
        @(posedge clk);
        #1;
        // Drop valid and scramble the command: the captured copy must be used.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr  = 7'($urandom); req1_addr = 7'($urandom);
        req0_wdata = 16'($urandom); req1_wdata = 16'($urandom);
        if (wait_rsp) drain("rsp_wait");
    endtask

    // Hold valid on port 0 (and port 1 when both=1) across n handshakes of reads.
    task automatic stream(input bit both, input int n);
        int   k, t;
        bit   p;
        iss_t ei;
        rsp_t er;
        drp_lat = 1;
        drp_val = 16'h0F0F;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 7'h01; req0_wdata = '0;
        req1_valid = both; req1_we = 1'b0; req1_addr = 7'h51; req1_wdata = '0;
        k = 0;
        t = 0;
        while (k < n && t < 200) begin
            @(negedge clk);
            t++;
            check("ready_excl", req0_ready && req1_ready, 0);
            if (req0_ready || req1_ready) begin
                p = req1_ready;
                if (both) check("grant_order", p, k % 2);
                ei.addr = p ? req1_addr : req0_addr; ei.we = 1'b0; ei.wdata = '0;
                iq.push_back(ei);
                er.port = p; er.data = drp_val; er.to = 1'b0;
                sb.push_back(er);
                k++;
                @(posedge clk);
                #1;
                if (p) req1_addr = req1_addr + 7'd1;
                else   req0_addr = req0_addr + 7'd1;
            end
        end
        check("stream_cnt", k, n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain("stream_drain");
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        drp_drdy = 0; drp_do = '0;

        fork
            // Cycle counter and DRP slave: drdy for one cycle when the countdown expires.
            forever begin
                @(posedge clk);
                cyc++;
                #1;
                drp_drdy = (pend == 1);
                drp_do   = drp_drdy ? drp_val : 16'h5A5A;
                if (pend > 0) pend--;
            end
            // Monitor: DRP issues and responses against the scoreboard.
            begin
                iss_t ei;
                rsp_t er;
                forever begin
                    @(negedge clk);
                    if (drp_den) begin
                        den_prev = den_cyc;
                        den_cyc  = cyc;
                        if (iq.size() == 0) check("den_unexpected", drp_den, 0);
                        else begin
                            ei = iq.pop_front();
                            check("daddr", drp_daddr, ei.addr);
                            check("dwe", drp_dwe, ei.we);
                            if (ei.we) check("di", drp_di, ei.wdata);
                        end
                        if (drp_lat >= 0) pend = drp_lat;
                    end
                    if (rsp0_valid || rsp1_valid) begin
                        rsp_cyc = cyc;
                        check("rsp_onehot", rsp0_valid && rsp1_valid, 0);
                        if (sb.size() == 0) check("rsp_unexpected", {rsp1_valid, rsp0_valid}, 0);
                        else begin
                            er = sb.pop_front();
                            if (er.port) begin
                                check("rsp1_valid", rsp1_valid, 1);
                                check("rsp1_rdata", rsp1_rdata, er.data);
                                check("rsp1_timeout", rsp1_timeout, er.to);
                                check("rsp0_hold", rsp0_rdata, hold0);
                                hold1 = er.data;
                            end else begin
                                check("rsp0_valid", rsp0_valid, 1);
                                check("rsp0_rdata", rsp0_rdata, er.data);
                                check("rsp0_timeout", rsp0_timeout, er.to);
                                check("rsp1_hold", rsp1_rdata, hold1);
                                hold0 = er.data;
                            end
                        end
                    end
                end
            end
        join_none

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {busy, drp_den, drp_dwe, rsp0_valid, rsp1_valid,
                           rsp0_timeout, rsp1_timeout, req0_ready, req1_ready}, 0);
        check("rst_daddr", drp_daddr, 0);
        check("rst_rdata", {rsp0_rdata, rsp1_rdata}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Contention straight after reset: 0,1,0,1.
        stream(1, 4);

        // Single read, drdy 3 cycles after den.
        do_req(0, 7'h14, 0, 16'h0, 3, 16'hABC0, 0, 1);
        check("lat_read3", rsp_cyc - hs_cyc, 5);

        // Write: read data comes back as 0 even though drp_do is non-zero.
        do_req(1, 7'h41, 1, 16'h2000, 3, 16'hBEEF, 0, 1);

        // Minimum latency.
        do_req(1, 7'h10, 0, 16'h0, 1, 16'h1234, 0, 1);
        check("lat_min", rsp_cyc - hs_cyc, 3);

        // Back-to-back on port 0: issues 4 cycles apart.
        stream(0, 2);
        check("b2b_spacing", den_cyc - den_prev, 4);

        // Timeout, then a stray drdy, then a normal transaction.
        do_req(0, 7'h22, 0, 16'h0, -1, 16'h0, 1, 1);
        check("to_latency", rsp_cyc - den_cyc, 65);
        repeat (4) @(negedge clk);
        pend = 1;
        repeat (5) @(negedge clk);
        do_req(0, 7'h23, 0, 16'h0, 2, 16'h7777, 0, 1);

        // drdy on the last WAIT cycle wins; one cycle later it is too late.
        do_req(0, 7'h30, 0, 16'h0, 64, 16'hC0DE, 0, 1);
        do_req(1, 7'h31, 0, 16'h0, 65, 16'hC0DE, 1, 1);

        // Asynchronous reset while in WAIT (port 0 owned it, so last_grant was 0).
        do_req(0, 7'h15, 0, 16'h0, -1, 16'h0, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rstw_busy", busy, 0);
        check("rstw_den", drp_den, 0);
        check("rstw_rsp", {rsp0_valid, rsp1_valid}, 0);
        check("rstw_rdata", rsp0_rdata, 0);
        sb.delete();
        iq.delete();
        hold0 = '0;
        hold1 = '0;
        @(negedge clk);
        rst = 1'b0;
        pend = 1;
        repeat (5) @(negedge clk);
        stream(1, 2);
        do_req(1, 7'h42, 0, 16'h0, 2, 16'h4242, 0, 1);

        // Asynchronous reset during ISSUE drops den immediately.
        do_req(1, 7'h43, 1, 16'h1111, -1, 16'h0, 0, 0);
        #2;
        check("rsti_den_pre", drp_den, 1);
        rst = 1'b1;
        #1;
        check("rsti_den", drp_den, 0);
        check("rsti_busy", busy, 0);
        sb.delete();
        iq.delete();
        hold0 = '0;
        hold1 = '0;
        @(negedge clk);
        rst = 1'b0;
        do_req(0, 7'h44, 0, 16'h0, 1, 16'h9999, 0, 1);

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("iq_empty", iq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
